sensor_threshold_monitor: RTL

Parametrised successor to the fixed five-register threshold CSR block. Holds per-channel threshold, hysteresis and debounce registers behind the same CPU CSR bus, and compares live sensor samples against them. Each channel runs an alarm state machine with debounce and hysteresis. Sticky write-1-to-clear status bits feed a maskable interrupt. Sits between the sensor sample pipeline and the system CPU in the clk_sys domain.

---
 rtl/sensor_threshold_monitor_pkg.sv | 34 +++
 rtl/sensor_threshold_monitor_channel_fsm.sv | 98 +++++++++
 rtl/sensor_threshold_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sensor_threshold_monitor_pkg.sv
// Shared constants, FSM state type and CSR request payload for the threshold monitor.
package sensor_threshold_monitor_pkg;

  localparam logic [31:0] CH_STRIDE   = 32'h10;
  localparam logic [31:0] GLOBAL_BASE = 32'h100;

  localparam logic [3:0] OFF_THRESH      = 4'h0;
  localparam logic [3:0] OFF_HYST        = 4'h4;
  localparam logic [3:0] OFF_DEBOUNCE    = 4'h8;
  localparam logic [3:0] OFF_LAST_SAMPLE = 4'hC;

  localparam logic [31:0] ADDR_STATUS = GLOBAL_BASE + 32'h0;
  localparam logic [31:0] ADDR_IRQ_EN = GLOBAL_BASE + 32'h4;
  localparam logic [31:0] ADDR_CTRL   = GLOBAL_BASE + 32'h8;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        rd;
    logic        wr;
  } csr_req_t;

  // Base byte address of a channel's register window.
  function automatic logic [31:0] ch_base(input int unsigned ch);
    return 32'(ch) * CH_STRIDE;
  endfunction

endpackage

// File: rtl/sensor_threshold_monitor_channel_fsm.sv
// Per-channel alarm state machine with debounce on entry and hysteresis on exit.
module threshold_channel_fsm
  import sensor_threshold_monitor_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEB_W  = 8
) (
  input  logic              clk_sys,
  input  logic              reset_clk_sys_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              valid,
  input  logic [DATA_W-1:0] thresh,
  input  logic [DATA_W-1:0] hyst,
  input  logic [DEB_W-1:0]  debounce,
  input  logic              enable,
  input  logic              restart,
  output logic              alarm,
  output logic              alarm_set_c
);

  localparam logic [DEB_W-1:0] CNT_MAX = '1;

  ch_state_e         state_q, state_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [DEB_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] clr_level;
  logic              above;
  logic              below_clr;

  // Compare helpers: saturating clear level and saturating counter increment.
  always_comb begin
    clr_level = (hyst >= thresh) ? '0 : (thresh - hyst);
    above     = (sample > thresh);
    below_clr = (sample < clr_level);
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + DEB_W'(1));
  end

  // Next-state logic; restart and disable dominate any sample.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alarm_set_c = 1'b0;
    if (restart || !enable) begin
      state_d = NORMAL;
      cnt_d   = '0;
    end else if (valid) begin
      case (state_q)
        NORMAL: begin
          if (above) begin
            cnt_d = DEB_W'(1);
            if (debounce <= DEB_W'(1)) begin
              state_d     = ALARM;
              alarm_set_c = 1'b1;
            end else begin
              state_d = PENDING;
            end
          end
        end
        PENDING: begin
          if (above) begin
            cnt_d = cnt_inc;
            if (cnt_inc == debounce) begin
              state_d     = ALARM;
              alarm_set_c = 1'b1;
            end
          end else begin
            state_d = NORMAL;
            cnt_d   = '0;
          end
        end
        ALARM: begin
          if (below_clr) begin
            state_d = NORMAL;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = NORMAL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and registered alarm flag.
  always_ff @(posedge clk_sys or negedge reset_clk_sys_n) begin
    if (!reset_clk_sys_n) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alarm   <= (state_d == ALARM);
    end
  end

endmodule

// File: rtl/sensor_threshold_monitor.sv
// CSR-mapped multi-channel threshold monitor with sticky status and maskable interrupt.
module sensor_threshold_monitor
  import sensor_threshold_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEB_W  = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset_clk_sys_n,
  input  logic [31:0]              csr_addr,
  input  logic                     csr_rd,
  input  logic                     csr_wr,
  input  logic                     csr_cs_n,
  input  logic [31:0]              csr_wr_data,
  output logic [31:0]              csr_rd_data,
  output logic                     csr_rd_valid,
  input  logic [NUM_CH-1:0]        sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  output logic [NUM_CH*DATA_W-1:0] threshold,
  output logic [NUM_CH-1:0]        alarm,
  output logic                     irq
);

  csr_req_t req;
  logic [3:0] reg_off;

  logic [DATA_W-1:0] thresh_q [NUM_CH];
  logic [DATA_W-1:0] hyst_q   [NUM_CH];
  logic [DEB_W-1:0]  deb_q    [NUM_CH];
  logic [DATA_W-1:0] last_q   [NUM_CH];
  logic [NUM_CH-1:0] status_q;
  logic [NUM_CH-1:0] irq_en_q;
  logic              ctrl_en_q;

  logic [NUM_CH-1:0] wr_thresh, wr_hyst, wr_deb;
  logic [NUM_CH-1:0] restart;
  logic [NUM_CH-1:0] alarm_set_c;
  logic [NUM_CH-1:0] w1c_mask;
  logic              wr_status, wr_irq_en, wr_ctrl, ctrl_off;
  logic [31:0]       rd_mux_c;
  logic              unused_wr_bits;

  assign req = '{addr: csr_addr, wr_data: csr_wr_data,
                 rd: csr_rd & ~csr_cs_n, wr: csr_wr & ~csr_cs_n};
  assign reg_off        = req.addr[3:0];
  assign unused_wr_bits = ^req.wr_data;

  // Write decode for per-channel and global registers.
  always_comb begin
    wr_thresh = '0;
    wr_hyst   = '0;
    wr_deb    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (req.wr && ({req.addr[31:4], 4'h0} == ch_base(c))) begin
        case (reg_off)
          OFF_THRESH:   wr_thresh[c] = 1'b1;
          OFF_HYST:     wr_hyst[c]   = 1'b1;
          OFF_DEBOUNCE: wr_deb[c]    = 1'b1;
          default: ;
        endcase
      end
    end
    wr_status = req.wr && (req.addr == ADDR_STATUS);
    wr_irq_en = req.wr && (req.addr == ADDR_IRQ_EN);
    wr_ctrl   = req.wr && (req.addr == ADDR_CTRL);
    ctrl_off  = wr_ctrl && !req.wr_data[0];
    restart   = wr_thresh | wr_hyst | wr_deb | {NUM_CH{ctrl_off}};
    w1c_mask  = wr_status ? req.wr_data[NUM_CH-1:0] : '0;
  end

  // Per-channel configuration registers and last-sample capture.
  always_ff @(posedge clk_sys or negedge reset_clk_sys_n) begin
    if (!reset_clk_sys_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        thresh_q[c] <= '0;
        hyst_q[c]   <= '0;
        deb_q[c]    <= '0;
        last_q[c]   <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wr_thresh[c]) thresh_q[c] <= req.wr_data[DATA_W-1:0];
        if (wr_hyst[c])   hyst_q[c]   <= req.wr_data[DATA_W-1:0];
        if (wr_deb[c])    deb_q[c]    <= req.wr_data[DEB_W-1:0];
        if (sample_valid[c]) last_q[c] <= sample_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // Global registers; a new alarm entry beats a same-cycle clear.
  always_ff @(posedge clk_sys or negedge reset_clk_sys_n) begin
    if (!reset_clk_sys_n) begin
      status_q  <= '0;
      irq_en_q  <= '0;
      ctrl_en_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      status_q <= (status_q & ~w1c_mask) | alarm_set_c;
      if (wr_irq_en) irq_en_q  <= req.wr_data[NUM_CH-1:0];
      if (wr_ctrl)   ctrl_en_q <= req.wr_data[0];
      irq <= |(status_q & irq_en_q);
    end
  end

  // Read mux over pre-write register contents.
  always_comb begin
    rd_mux_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if ({req.addr[31:4], 4'h0} == ch_base(c)) begin
        case (reg_off)
          OFF_THRESH:      rd_mux_c = 32'(thresh_q[c]);
          OFF_HYST:        rd_mux_c = 32'(hyst_q[c]);
          OFF_DEBOUNCE:    rd_mux_c = 32'(deb_q[c]);
          OFF_LAST_SAMPLE: rd_mux_c = 32'(last_q[c]);
          default: ;
        endcase
      end
    end
    case (req.addr)
      ADDR_STATUS: rd_mux_c = 32'(status_q);
      ADDR_IRQ_EN: rd_mux_c = 32'(irq_en_q);
      ADDR_CTRL:   rd_mux_c = 32'(ctrl_en_q);
      default: ;
    endcase
  end

  // Registered read response; data holds until the next read.
  always_ff @(posedge clk_sys or negedge reset_clk_sys_n) begin
    if (!reset_clk_sys_n) begin
      csr_rd_data  <= '0;
      csr_rd_valid <= 1'b0;
    end else begin
      csr_rd_valid <= req.rd;
      if (req.rd) csr_rd_data <= rd_mux_c;
    end
  end

  // One alarm FSM per channel plus threshold export.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign threshold[c*DATA_W +: DATA_W] = thresh_q[c];

    threshold_channel_fsm #(
      .DATA_W (DATA_W),
      .DEB_W  (DEB_W)
    ) u_fsm (
      .clk_sys         (clk_sys),
      .reset_clk_sys_n (reset_clk_sys_n),
      .sample          (sample_data[c*DATA_W +: DATA_W]),
      .valid           (sample_valid[c]),
      .thresh          (thresh_q[c]),
      .hyst            (hyst_q[c]),
      .debounce        (deb_q[c]),
      .enable          (ctrl_en_q),
      .restart         (restart[c]),
      .alarm           (alarm[c]),
      .alarm_set_c     (alarm_set_c[c])
    );
  end

endmodule
